regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Hazard scoreboard and issue controller for the integer register file. It keeps a busy bit for each architectural register x1..x31 and stalls issue on read-after-write and write-after-write hazards. Busy bits clear when the ALU writeback port or the memory-access-unit (MAU) writeback port retires a write. It also bounds the number of outstanding loads and flags protocol violations. It sits between decode/issue and the register file, watching the same rd/rdmau write strobes that drive the file.

## Interface
Parameters:
- MAX_LOADS, 4: maximum outstanding loads (range 1..15).
- CNT_W, $clog2(MAX_LOADS+1): width of load_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1, issue_rs2  in  5  source register indices.
- issue_rs1_en, issue_rs2_en  in  1  source operand is used.
- issue_rd  in  5  destination register index.
- issue_rd_en  in  1  instruction writes rd.
- issue_is_load  in  1  instruction is a load; its rd retires through the MAU port.
- issue_stall  out  1  combinational; instruction is not accepted this cycle.
- wb_en, wb_rd  in  1, 5  ALU writeback strobe and index (same as the file's rd_en/rd).
- mau_en, mau_rd  in  1, 5  MAU writeback strobe and index (same as the file's rdmau_en/rdmau).
- busy  out  32  registered busy vector; bit 0 is constant 0.
- load_cnt  out  CNT_W  registered count of outstanding loads.
- err  out  1  registered sticky protocol-error flag.

## Operation
- accept = issue_valid & ~issue_stall.
- issue_stall = issue_valid & (raw1 | raw2 | waw | lfull).
  - raw1 = issue_rs1_en & (issue_rs1 != 0) & busy[issue_rs1]. raw2 is the same for rs2.
  - waw = issue_rd_en & (issue_rd != 0) & busy[issue_rd].
  - lfull = issue_is_load & (load_cnt == MAX_LOADS).
- There is no bypass. Stall uses registered busy only, because the file's read is combinational and reads the pre-edge value. A register being retired in the same cycle still stalls.
- Set: on accept with issue_rd_en and issue_rd != 0, busy[issue_rd] <= 1.
- Clear: wb_en with wb_rd != 0 clears busy[wb_rd]. mau_en with mau_rd != 0 clears busy[mau_rd]. If both ports target the same index, it is cleared once and this is not an error.
- Set and clear on the same index in the same cycle: set wins.
- Load counter:
  - +1 on accept & issue_is_load.
  - -1 on mau_en.
  - Both in the same cycle: unchanged.
  - Never wraps. A decrement at 0 holds 0. An increment is impossible at MAX_LOADS because of lfull.
- err is set (and holds until reset) on any of:
  - wb_en or mau_en to a nonzero index whose busy bit is 0;
  - mau_en while load_cnt == 0 with no same-cycle load accept;
  - accept with issue_is_load & ~issue_rd_en.
- Index 0 writes are ignored silently and are never errors.

## Timing
- Reset (async, reset low): busy = 0, load_cnt = 0, err = 0. issue_stall is then 0 for any input, since no bit is busy and the count is below MAX_LOADS.
- Reset asserted mid-operation discards all pending state immediately. Writebacks for instructions issued before reset are then flagged as err if they arrive after reset deasserts.
- All state updates on the rising clk edge. issue_stall has zero latency (combinational) from issue_* and registered state.
- Issue-to-busy latency is 1 cycle: an instruction accepted in cycle N makes busy[rd] = 1 from cycle N+1. A dependent instruction in cycle N+1 stalls.
- Retire-to-unstall latency is 1 cycle: a writeback in cycle M clears busy in M+1. A dependent instruction issues in M+1 and reads the value the file wrote at edge M.
- Single-cycle ALU path: issue in N, wb_en in N+1 clears the bit, so a dependent instruction can issue in N+2.
- issue_valid low: issue_stall = 0 and no set occurs.

## Test plan
- Reset, then issue rd=5 (non-load) in cycle 0 and rs1=5 in cycle 1 -> stall=1 in cycle 1. wb_en rd=5 in cycle 1 -> stall=0 in cycle 2, busy=0, err=0.
- Issue rs1=0, rd=0 with all busy bits set -> stall=0, busy[0] stays 0.
- MAX_LOADS=4: issue loads to x1..x4 -> load_cnt=4. A fifth load to x6 -> stall=1. mau_en x1 alongside the fifth load -> stall still 1 that cycle, accepted next cycle, load_cnt stays 4.
- wb_en and mau_en both to busy x7 in one cycle -> busy[7]=0, err=0, load_cnt decremented by 1.
- wb_en to non-busy x9 -> err=1 next cycle. It stays 1 through further traffic until reset is pulsed low, then err=0.
- Issue rd=3 accepted in the same cycle as a stale wb_en rd=3 -> busy[3]=1 next cycle (set wins) and err=1.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Busy-bit hazard scoreboard and issue gate for the integer file,
//            with an outstanding-load limiter and sticky protocol-error flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
    parameter int MAX_LOADS = 4,
    parameter int CNT_W     = $clog2(MAX_LOADS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs1,
    input  logic [4:0]       issue_rs2,
    input  logic             issue_rs1_en,
    input  logic             issue_rs2_en,
    input  logic [4:0]       issue_rd,
    input  logic             issue_rd_en,
    input  logic             issue_is_load,
    output logic             issue_stall,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic             mau_en,
    input  logic [4:0]       mau_rd,
    output logic [31:0]      busy,
    output logic [CNT_W-1:0] load_cnt,
    output logic             err
);

    localparam logic [CNT_W-1:0] C_MAX_LOADS = CNT_W'(MAX_LOADS);
    localparam logic [31:0]      C_ONE       = 32'd1;

    logic [31:0]      r_busy;
    logic [CNT_W-1:0] r_load_cnt;
    logic             r_err;

    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;
    logic             w_lfull;
    logic             w_accept;
    logic             w_load_inc;
    logic             w_wb_act;
    logic             w_mau_act;
    logic [31:0]      w_set_vec;
    logic [31:0]      w_clr_vec;
    logic [31:0]      w_busy_nxt;
    logic             w_err_evt;

    // Hazards look only at registered busy: the file reads its pre-edge value,
    // so a same-cycle retire cannot be bypassed.
    assign w_raw1  = issue_rs1_en & (issue_rs1 != 5'd0) & r_busy[issue_rs1];
    assign w_raw2  = issue_rs2_en & (issue_rs2 != 5'd0) & r_busy[issue_rs2];
    assign w_waw   = issue_rd_en  & (issue_rd  != 5'd0) & r_busy[issue_rd];
    assign w_lfull = issue_is_load & (r_load_cnt == C_MAX_LOADS);

    assign issue_stall = issue_valid & (w_raw1 | w_raw2 | w_waw | w_lfull);
    assign w_accept    = issue_valid & ~issue_stall;
    assign w_load_inc  = w_accept & issue_is_load;

    assign w_wb_act  = wb_en  & (wb_rd  != 5'd0);
    assign w_mau_act = mau_en & (mau_rd != 5'd0);

    assign w_set_vec = (w_accept & issue_rd_en & (issue_rd != 5'd0)) ? (C_ONE << issue_rd) : 32'd0;
    assign w_clr_vec = (w_wb_act  ? (C_ONE << wb_rd)  : 32'd0)
                     | (w_mau_act ? (C_ONE << mau_rd) : 32'd0);

    // Set is applied after clear so that a same-index set wins.
    assign w_busy_nxt = ((r_busy & ~w_clr_vec) | w_set_vec) & ~C_ONE;

    assign w_err_evt = (w_wb_act  & ~r_busy[wb_rd])
                     | (w_mau_act & ~r_busy[mau_rd])
                     | (mau_en & (r_load_cnt == '0) & ~w_load_inc)
                     | (w_load_inc & ~issue_rd_en);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy     <= 32'd0;
            r_load_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_load_inc && !mau_en) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end else if (mau_en && !w_load_inc && (r_load_cnt != '0)) begin
                r_load_cnt <= r_load_cnt - 1'b1;
            end
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign load_cnt = r_load_cnt;
    assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// Module   : tb_regfile_scoreboard
// Purpose  : Directed stimulus with a queued expectation scoreboard for
//            regfile_scoreboard; a monitor compares on each falling edge.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid, issue_rs1_en, issue_rs2_en, issue_rd_en, issue_is_load;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        issue_stall;
    logic        wb_en, mau_en;
    logic [4:0]  wb_rd, mau_rd;
    logic [31:0] busy;
    logic [2:0]  load_cnt;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [3:0]  mask;   // {stall, busy, cnt, err}
        logic        stall;
        logic [31:0] busy;
        logic [2:0]  cnt;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    regfile_scoreboard #(.MAX_LOADS(4)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs1_en(issue_rs1_en), .issue_rs2_en(issue_rs2_en),
        .issue_rd(issue_rd), .issue_rd_en(issue_rd_en), .issue_is_load(issue_is_load),
        .issue_stall(issue_stall),
        .wb_en(wb_en), .wb_rd(wb_rd), .mau_en(mau_en), .mau_rd(mau_rd),
        .busy(busy), .load_cnt(load_cnt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_en = 0; issue_rs2_en = 0;
        issue_rd = 0; issue_rd_en = 0; issue_is_load = 0;
        wb_en = 0; wb_rd = 0; mau_en = 0; mau_rd = 0;
    endtask

    task automatic iss(input logic [4:0] rs1, input logic rs1en, input logic [4:0] rs2,
                       input logic rs2en, input logic [4:0] rd, input logic rden, input logic ld);
        issue_valid = 1; issue_rs1 = rs1; issue_rs1_en = rs1en; issue_rs2 = rs2;
        issue_rs2_en = rs2en; issue_rd = rd; issue_rd_en = rden; issue_is_load = ld;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_en = 1; wb_rd = r;
    endtask

    task automatic mau(input logic [4:0] r);
        mau_en = 1; mau_rd = r;
    endtask

    task automatic expect_(input string nm, input logic [3:0] m, input logic st,
                           input logic [31:0] b, input logic [2:0] c, input logic e);
        exp_t x;
        x.name = nm; x.mask = m; x.stall = st; x.busy = b; x.cnt = c; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Reset is held low across one rising edge; issue_valid is driven to show
    // that nothing stalls while in reset.
    task automatic do_reset(input string nm);
        idle();
        reset = 0;
        iss(5'd5, 1, 5'd6, 1, 5'd7, 1, 1);
        expect_(nm, 4'b1111, 0, 32'd0, 3'd0, 0);
        @(posedge clk);
        #1;
        reset = 1;
        idle();
    endtask

    // Monitor: the DUT presents its state every cycle; compare whenever an
    // expectation has been queued for this cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            if (x.mask[3]) begin
                n_tests++;
                if (issue_stall !== x.stall) begin
                    n_fail++;
                    $display("FAIL %s.stall: got %0b expected %0b", x.name, issue_stall, x.stall);
                end
            end
            if (x.mask[2]) begin
                n_tests++;
                if (busy !== x.busy) begin
                    n_fail++;
                    $display("FAIL %s.busy: got %08h expected %08h", x.name, busy, x.busy);
                end
            end
            if (x.mask[1]) begin
                n_tests++;
                if (load_cnt !== x.cnt) begin
                    n_fail++;
                    $display("FAIL %s.load_cnt: got %0d expected %0d", x.name, load_cnt, x.cnt);
                end
            end
            if (x.mask[0]) begin
                n_tests++;
                if (err !== x.err) begin
                    n_fail++;
                    $display("FAIL %s.err: got %0b expected %0b", x.name, err, x.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        @(posedge clk);
        #1;
        do_reset("reset0");

        // RAW on a single-cycle ALU result
        iss(0, 0, 0, 0, 5'd5, 1, 0);
        expect_("raw_issue", 4'b1111, 0, 32'd0, 3'd0, 0); tick();
        iss(5'd5, 1, 0, 0, 5'd6, 1, 0); wb(5'd5);
        expect_("raw_stall", 4'b1111, 1, 32'h0000_0020, 3'd0, 0); tick();
        iss(5'd5, 1, 0, 0, 5'd6, 1, 0);
        expect_("raw_release", 4'b1111, 0, 32'd0, 3'd0, 0); tick();
        wb(5'd6);
        expect_("rd6_busy", 4'b0101, 0, 32'h0000_0040, 3'd0, 0); tick();
        expect_("rd6_clear", 4'b0111, 0, 32'd0, 3'd0, 0); tick();

        // All registers busy; x0 never hazards
        for (int i = 1; i < 32; i++) begin
            iss(0, 0, 0, 0, 5'(i), 1, 0);
            tick();
        end
        iss(5'd0, 1, 5'd0, 1, 5'd0, 1, 0);
        expect_("x0_nostall", 4'b1101, 0, 32'hFFFF_FFFE, 3'd0, 0); tick();
        iss(5'd17, 1, 0, 0, 0, 0, 0);
        expect_("rs1_17_stall", 4'b1100, 1, 32'hFFFF_FFFE, 3'd0, 0); tick();
        iss(0, 0, 5'd31, 1, 0, 0, 0);
        expect_("rs2_31_stall", 4'b1000, 1, 32'd0, 3'd0, 0); tick();
        iss(0, 0, 0, 0, 5'd12, 1, 0);
        expect_("waw_stall", 4'b1000, 1, 32'd0, 3'd0, 0); tick();
        do_reset("reset1");

        // Load limit
        for (int k = 1; k <= 4; k++) begin
            iss(0, 0, 0, 0, 5'(k), 1, 1);
            tick();
        end
        iss(0, 0, 0, 0, 5'd6, 1, 1); mau(5'd1);
        expect_("lfull_stall", 4'b1111, 1, 32'h0000_001E, 3'd4, 0); tick();
        iss(0, 0, 0, 0, 5'd6, 1, 1);
        expect_("load5_accept", 4'b1111, 0, 32'h0000_001C, 3'd3, 0); tick();
        iss(0, 0, 0, 0, 5'd8, 1, 0);
        expect_("nonload_at_full", 4'b1111, 0, 32'h0000_005C, 3'd4, 0); tick();
        expect_("full_state", 4'b0111, 0, 32'h0000_015C, 3'd4, 0); tick();
        do_reset("reset2");

        // Dual retire of the same index
        iss(0, 0, 0, 0, 5'd7, 1, 1);
        expect_("load7", 4'b1000, 0, 32'd0, 3'd0, 0); tick();
        wb(5'd7); mau(5'd7);
        expect_("dual_pre", 4'b0111, 0, 32'h0000_0080, 3'd1, 0); tick();
        expect_("dual_post", 4'b0111, 0, 32'd0, 3'd0, 0); tick();

        // MAU at zero count: counter holds, flag sets
        mau(5'd0);
        tick();
        expect_("mau_at_zero", 4'b0011, 0, 32'd0, 3'd0, 1); tick();
        do_reset("reset3");

        // Load without a destination
        iss(0, 0, 0, 0, 5'd0, 0, 1);
        tick();
        expect_("load_no_rd", 4'b0111, 0, 32'd0, 3'd1, 1); tick();
        do_reset("reset4");

        // Sticky error from a stale writeback
        wb(5'd9);
        expect_("stale_pre", 4'b0001, 0, 32'd0, 3'd0, 0); tick();
        iss(0, 0, 0, 0, 5'd2, 1, 0);
        expect_("sticky1", 4'b0101, 0, 32'd0, 3'd0, 1); tick();
        wb(5'd2);
        expect_("sticky2", 4'b0101, 0, 32'h0000_0004, 3'd0, 1); tick();
        expect_("sticky3", 4'b0101, 0, 32'd0, 3'd0, 1); tick();
        do_reset("reset5");
        expect_("err_cleared", 4'b0111, 0, 32'd0, 3'd0, 0); tick();

        // Reset discards pending work; a late writeback is then a protocol error
        iss(0, 0, 0, 0, 5'd4, 1, 0);
        tick();
        expect_("pending4", 4'b0100, 0, 32'h0000_0010, 3'd0, 0); tick();
        do_reset("reset6");
        wb(5'd4);
        expect_("late_wb_pre", 4'b0101, 0, 32'd0, 3'd0, 0); tick();
        expect_("late_wb_err", 4'b0101, 0, 32'd0, 3'd0, 1); tick();
        do_reset("reset7");

        // Set wins over a same-cycle stale clear
        iss(0, 0, 0, 0, 5'd3, 1, 0); wb(5'd3);
        expect_("setwin_pre", 4'b1101, 0, 32'd0, 3'd0, 0); tick();
        expect_("setwin_post", 4'b0101, 0, 32'h0000_0008, 3'd0, 1); tick();

        repeat (2) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
